// File: rtl/run_ctrl.sv
// run_ctrl: run/halt sequencer for a small processor core.
// Ports:
//   CLK           - clock, all state changes on the rising edge
//   Reset         - synchronous active-high reset
//   start         - host run request, level-sampled every edge
//   halt_instr    - instruction at PC is the halt instruction
//   branch_taken  - take branch this cycle
//   branch_target - next PC when branch_taken
//   PC            - instruction ROM address (registered)
//   run           - commit enable for architectural writes (registered)
//   halt          - run finished, normally or by watchdog (registered)
//   timeout       - last run was ended by the watchdog (registered)
//   cycle_count   - instructions executed in current/last run (registered)
module run_ctrl #(
    parameter int unsigned PC_W       = 8,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned MAX_CYCLES = 1023
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            start,
    input  logic            halt_instr,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] PC,
    output logic            run,
    output logic            halt,
    output logic            timeout,
    output logic [15:0]     cycle_count
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
    localparam logic [15:0]     WD_LAST  = 16'(MAX_CYCLES - 1);
    localparam logic [15:0]     WD_MAX   = 16'(MAX_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        HALTED
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            run_q, run_d;
    logic            halt_q, halt_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     count_q, count_d;
    logic [15:0]     count_inc;

    // Count saturates rather than wrapping.
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            run_q     <= 1'b0;
            halt_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            run_q     <= run_d;
            halt_q    <= halt_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        run_d     = run_q;
        halt_d    = halt_q;
        timeout_d = timeout_q;
        count_d   = count_q;

        if (start) begin
            // A start request aborts whatever is going on.
            state_d   = INIT;
            pc_d      = START_PC;
            run_d     = 1'b0;
            halt_d    = 1'b0;
            timeout_d = 1'b0;
            count_d   = 16'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                INIT: begin
                    state_d = RUN;
                    run_d   = 1'b1;
                end
                RUN: begin
                    if (halt_instr) begin
                        // Halt wins over the watchdog; halt counts as executed.
                        state_d = HALTED;
                        run_d   = 1'b0;
                        halt_d  = 1'b1;
                        count_d = count_inc;
                    end else if (count_q == WD_LAST) begin
                        state_d   = HALTED;
                        run_d     = 1'b0;
                        halt_d    = 1'b1;
                        timeout_d = 1'b1;
                        count_d   = WD_MAX;
                    end else begin
                        pc_d    = branch_taken ? branch_target
                                               : pc_q + PC_W'(1);
                        count_d = count_inc;
                    end
                end
                HALTED: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign PC          = pc_q;
    assign run         = run_q;
    assign halt        = halt_q;
    assign timeout     = timeout_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: scoreboard bench for run_ctrl.
// A reference model predicts outputs per edge; results compared after the edge.
module tb_run_ctrl;

    localparam int MAXC = 10;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        halt_instr = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic [7:0]  PC;
    logic        run;
    logic        halt;
    logic        timeout;
    logic [15:0] cycle_count;

    run_ctrl #(
        .PC_W(8),
        .START_ADDR(0),
        .MAX_CYCLES(MAXC)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .start(start),
        .halt_instr(halt_instr),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .PC(PC),
        .run(run),
        .halt(halt),
        .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]  pc;
        logic        run;
        logic        halt;
        logic        to;
        logic [15:0] cnt;
    } exp_t;

    typedef enum int {M_IDLE, M_INIT, M_RUN, M_HALT} mst_t;

    exp_t        sb[$];
    mst_t        m_st = M_IDLE;
    logic [7:0]  m_pc = 8'h00;
    logic        m_run = 1'b0;
    logic        m_halt = 1'b0;
    logic        m_to = 1'b0;
    logic [15:0] m_cnt = 16'd0;

    int checks = 0;
    int failures = 0;
    int runs = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic s, input logic hi,
                         input logic bt, input logic [7:0] tgt);
        logic [15:0] nxt;
        if (r) begin
            m_st = M_IDLE; m_pc = 8'h00; m_run = 0;
            m_halt = 0; m_to = 0; m_cnt = 0;
        end else if (s) begin
            m_st = M_INIT; m_pc = 8'h00; m_run = 0;
            m_halt = 0; m_to = 0; m_cnt = 0;
        end else if (m_st == M_INIT) begin
            m_st = M_RUN;
            m_run = 1;
        end else if (m_st == M_RUN) begin
            nxt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1;
            if (hi) begin
                m_st = M_HALT; m_run = 0; m_halt = 1; m_cnt = nxt;
            end else if (int'(m_cnt) == MAXC - 1) begin
                m_st = M_HALT; m_run = 0; m_halt = 1; m_to = 1;
                m_cnt = 16'(MAXC);
            end else begin
                if (bt) m_pc = tgt;
                else m_pc = m_pc + 8'd1;
                m_cnt = nxt;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic hi,
                        input logic bt, input logic [7:0] tgt);
        exp_t e;
        @(negedge CLK);
        Reset = r;
        start = s;
        halt_instr = hi;
        branch_taken = bt;
        branch_target = tgt;
        model(r, s, hi, bt, tgt);
        sb.push_back('{pc: m_pc, run: m_run, halt: m_halt,
                       to: m_to, cnt: m_cnt});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk("pc", 32'(PC), 32'(e.pc));
        chk("run", 32'(run), 32'(e.run));
        chk("halt", 32'(halt), 32'(e.halt));
        chk("timeout", 32'(timeout), 32'(e.to));
        chk("cnt", 32'(cycle_count), 32'(e.cnt));
        if (run === 1'b1) runs++;
    endtask

    task automatic go(input logic hi, input logic bt, input logic [7:0] tgt);
        step(1'b0, 1'b0, hi, bt, tgt);
    endtask

    initial begin
        // Reset overrides start.
        step(1, 1, 0, 0, 8'h00);
        step(1, 1, 1, 1, 8'h55);
        chk("rst_pc", 32'(PC), 0);
        chk("rst_halt", 32'(halt), 0);
        step(0, 0, 1, 1, 8'h33);
        chk("idle_pc", 32'(PC), 0);

        // Basic run, halt at PC 5.
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        runs = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_st == M_HALT) break;
            go(m_st == M_RUN && m_pc == 8'd5, 1'b0, 8'h00);
        end
        chk("r33_runs", 32'(runs), 6);
        chk("r33_halt", 32'(halt), 1);
        chk("r33_cnt", 32'(cycle_count), 6);
        chk("r33_pc", 32'(PC), 5);
        chk("r33_to", 32'(timeout), 0);
        for (int i = 0; i < 3; i++) go(1'b1, 1'b1, 8'hAA);
        chk("held_pc", 32'(PC), 5);

        // Branch and PC wrap.
        step(0, 1, 0, 0, 8'h00);
        go(0, 0, 8'h00);
        go(0, 0, 8'h00);
        go(0, 0, 8'h00);
        go(0, 0, 8'h00);
        go(0, 1, 8'hF0);
        chk("br_f0", 32'(PC), 32'h0F0);
        go(0, 1, 8'hFE);
        go(0, 0, 8'h00);
        chk("pc_ff", 32'(PC), 32'h0FF);
        go(0, 0, 8'h00);
        chk("wrap", 32'(PC), 0);
        go(1, 0, 8'h00);
        chk("wrap_halt", 32'(halt), 1);

        // Watchdog.
        step(0, 1, 0, 0, 8'h00);
        go(0, 0, 8'h00);
        for (int i = 0; i < 12; i++) go(0, 0, 8'h00);
        chk("wd_halt", 32'(halt), 1);
        chk("wd_to", 32'(timeout), 1);
        chk("wd_cnt", 32'(cycle_count), 32'(MAXC));
        chk("wd_run", 32'(run), 0);
        chk("wd_pc", 32'(PC), 9);

        // Halt with branch in same cycle.
        step(0, 1, 0, 0, 8'h00);
        go(0, 0, 8'h00);
        go(0, 0, 8'h00);
        go(0, 0, 8'h00);
        go(1, 1, 8'h77);
        chk("hb_pc", 32'(PC), 2);
        chk("hb_to", 32'(timeout), 0);
        chk("hb_halt", 32'(halt), 1);

        // Halt exactly at watchdog limit.
        step(0, 1, 0, 0, 8'h00);
        go(0, 0, 8'h00);
        for (int i = 0; i < 9; i++) go(0, 0, 8'h00);
        go(1, 0, 8'h00);
        chk("hw_to", 32'(timeout), 0);
        chk("hw_halt", 32'(halt), 1);
        chk("hw_cnt", 32'(cycle_count), 32'(MAXC));
        chk("hw_pc", 32'(PC), 9);

        // Abort by start, then reset mid-run.
        step(0, 1, 0, 0, 8'h00);
        go(0, 0, 8'h00);
        for (int i = 0; i < 4; i++) go(0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        chk("ab_cnt", 32'(cycle_count), 0);
        chk("ab_halt", 32'(halt), 0);
        chk("ab_run", 32'(run), 0);
        go(0, 0, 8'h00);
        go(0, 0, 8'h00);
        go(0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        chk("rr_run", 32'(run), 0);
        chk("rr_pc", 32'(PC), 0);
        chk("rr_cnt", 32'(cycle_count), 0);
        for (int i = 0; i < 3; i++) go(1'b1, 1'b1, 8'h12);
        chk("rr_idle", 32'(run), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 31) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0,
                 8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter PC_W, default 8: program counter width in bits.
REQ-002 Parameter START_ADDR, default 0: PC value loaded when a run begins.
REQ-003 Parameter MAX_CYCLES, default 1023: watchdog limit on executed cycles per run (≥1, < 2^16).
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  host run request; level-sampled each edge.
REQ-007 halt_instr  input  1  decoder flag: instruction at current PC is the halt instruction.
REQ-008 branch_taken  input  1  datapath flag: take branch this cycle.
REQ-009 branch_target  input  PC_W  next PC when branch_taken.
REQ-010 PC  output  PC_W  instruction-ROM address, registered.
REQ-011 run  output  1  commit enable for register file / data memory writes, registered.
REQ-012 halt  output  1  run finished (normal or watchdog), registered.
REQ-013 timeout  output  1  last run ended by watchdog, registered.
REQ-014 cycle_count  output  16  instructions executed in current/last run, registered.

Function
REQ-015 FSM states SHALL be IDLE, INIT, RUN, HALTED; one-hot or binary at implementer's choice.
REQ-016 start=1 in any state SHALL move to INIT next edge: PC<=START_ADDR, cycle_count<=0, halt<=0, timeout<=0, run<=0.
REQ-017 INIT with start=1 SHALL remain INIT with all outputs held at INIT values.
REQ-018 INIT with start=0 SHALL move to RUN next edge; PC unchanged, run<=1.
REQ-019 RUN: run SHALL be 1 for every cycle the FSM is in RUN.
REQ-020 RUN, halt_instr=1: next state HALTED, PC held, run<=0, halt<=1, cycle_count increments once (halt counts as executed).
REQ-021 RUN, halt_instr=0, branch_taken=1: PC<=branch_target.
REQ-022 RUN, halt_instr=0, branch_taken=0: PC<=PC+1 modulo 2^PC_W (wraps from all-ones to 0, no flag).
REQ-023 RUN: cycle_count SHALL increment by 1 per RUN cycle, saturating at 16'hFFFF.
REQ-024 Watchdog: in RUN with halt_instr=0 and cycle_count==MAX_CYCLES-1, next state HALTED, cycle_count<=MAX_CYCLES, timeout<=1, halt<=1, run<=0, PC held.
REQ-025 Priority in RUN: start > halt_instr > watchdog > branch_taken > increment.
REQ-026 halt_instr and watchdog same cycle: normal halt, timeout SHALL stay 0.
REQ-027 HALTED: halt=1, run=0, PC/cycle_count/timeout held until start=1.
REQ-028 IDLE: all outputs at reset values; halt_instr/branch inputs ignored outside RUN.
REQ-029 halt SHALL go high exactly one edge after the edge sampling halt_instr=1 in RUN (latency 1).
REQ-030 start asserted mid-RUN SHALL abort the run via INIT; no halt pulse is produced.

Reset
REQ-031 Reset=1 SHALL override all inputs including start: state IDLE, PC=START_ADDR, run=0, halt=0, timeout=0, cycle_count=0 at next edge.
REQ-032 Reset asserted mid-RUN or in HALTED SHALL yield same values as REQ-031; deassertion leaves FSM in IDLE until start.

Verification
REQ-033 Reset, start=1 two cycles then 0, halt_instr=1 when PC==5 -> PC 0,1..5, run high 6 cycles, halt=1 next edge, cycle_count=6, timeout=0.
REQ-034 RUN at PC=3, branch_taken=1, branch_target=8'hF0 -> PC=F0 next edge; later PC=FF no branch -> PC=00.
REQ-035 MAX_CYCLES=10, halt_instr never asserted -> halt=1, timeout=1, cycle_count=10, run=0 after 10 RUN cycles; PC held.
REQ-036 halt_instr=1 and branch_taken=1 same cycle, and separately halt_instr at watchdog limit -> HALTED, PC held, timeout=0 both cases.
REQ-037 start pulse at cycle 4 of RUN, then Reset pulse during a later RUN -> INIT values (cycle_count=0, halt=0) then IDLE with all outputs at reset values.
